mesh_edge_collector: RTL and testbench
======================================

MESH_EDGE_COLLECTOR -- requirements
Module: mesh_edge_collector

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8: thread PC width; channel payload is PC_WIDTH+1 bits.
REQ-002 SHALL have parameter LATENCY_COUNT_WIDTH, default 8: passed to every channel_iface instance.
REQ-003 SHALL have parameter FIFO_COUNT_WIDTH, default 3: buffer depth DEPTH = 2**FIFO_COUNT_WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port x_in  channel_iface.in  PC_WIDTH+1  threads leaving the mesh east edge.
REQ-007 SHALL have port y_in  channel_iface.in  PC_WIDTH+1  threads leaving the mesh south edge.
REQ-008 SHALL have port out  channel_iface.out  PC_WIDTH+1  threads re-injected into the first mesh node.
REQ-009 SHALL have port flush  input  1  discard all buffered threads (end of character).
REQ-010 SHALL have port count  output  FIFO_COUNT_WIDTH+1  buffer occupancy.
REQ-011 SHALL have port full  output  1  count == DEPTH.
REQ-012 SHALL have port running  output  1  collector holds or is offered work.

Function
REQ-013 A transfer SHALL occur on a port exactly when valid and ready are both high at a rising clk edge.
REQ-014 No input ready SHALL depend combinationally on any valid; both readies derive from registered count, registered priority, state and flush only.
REQ-015 Buffer SHALL be a DEPTH-entry FIFO that preserves arrival order; payload SHALL pass unmodified, MSB included.
REQ-016 With free slots >= 2, x_in.ready and y_in.ready SHALL both be high; on a dual transfer, y_in data SHALL be enqueued ahead of x_in data.
REQ-017 With exactly 1 free slot, only the port named by the 1-bit priority register SHALL be ready; priority SHALL toggle after each transfer made in this condition.
REQ-018 With 0 free slots, both readies SHALL be low, even when out pops in the same cycle (no bypass).
REQ-019 out.valid SHALL be high iff count != 0 and state != FLUSH and flush is low; out.data SHALL be the FIFO head.
REQ-020 Minimum latency from input transfer to out.valid SHALL be 1 cycle; no combinational input-to-output data path.
REQ-021 Simultaneous push and pop SHALL be legal; count SHALL update by pushes minus pops, range 0..DEPTH, with no wrap.
REQ-022 FIFO read/write pointers SHALL be FIFO_COUNT_WIDTH bits and wrap modulo DEPTH.
REQ-023 The state machine SHALL have three states: IDLE (count 0), ACTIVE (count > 0), FLUSH.
REQ-024 IDLE SHALL go to ACTIVE on any push; ACTIVE SHALL go to IDLE when count reaches 0.
REQ-025 flush high at any edge SHALL move to FLUSH, clear count and pointers, and set priority to y_in.
REQ-026 FLUSH SHALL be held while flush stays high, and SHALL go to IDLE at the first edge with flush low.
REQ-027 While flush is high or state is FLUSH, both readies and out.valid SHALL be 0; transfers offered in that cycle are not accepted.
REQ-028 running SHALL = (count != 0) | x_in.valid | y_in.valid | (state == FLUSH).
REQ-029 full SHALL = (count == DEPTH), registered-equivalent (derived from count only).

Reset
REQ-030 When rst is low: state IDLE, count 0, pointers 0, priority y_in, out.valid 0, both readies 0, full 0.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered threads; no transfer SHALL complete while rst is low.
REQ-032 After rst deasserts, readies SHALL rise at the first edge.

Structure
REQ-033 Shared package SHALL hold the state enum mesh_edge_state_t {IDLE, ACTIVE, FLUSH} and the thread payload width constant.
REQ-034 Storage SHALL be one sub-module, thread_fifo (parameterised depth/width, push/pop/count); arbitration and the FSM stay in mesh_edge_collector.
REQ-035 Unused channel_iface fields SHALL be driven to 0 on out.

Verification
REQ-036 After reset: x_in sends 0x105, 0x003 on consecutive cycles, out.ready=1 -> out shows 0x105 then 0x003, each 1 cycle after acceptance; count returns to 0.
REQ-037 Both inputs valid with x=0x011, y=0x022 into an empty FIFO -> both accepted same cycle; out order 0x022, 0x011.
REQ-038 DEPTH=8, out.ready=0, both ports continuously valid -> count reaches 7; at that point exactly one port (y first, then alternating after drain and refill) is ready; at 8, full=1 and both readies 0.
REQ-039 Full FIFO, out.ready=1, inputs valid -> pop occurs, no push that cycle; push resumes the next cycle.
REQ-040 count=5, flush pulsed 1 cycle while x_in.valid -> x_in not accepted; count=0, out.valid=0, IDLE next-next edge; running=1 during FLUSH.
REQ-041 rst driven low asynchronously mid-cycle with count=4 -> out.valid, count and readies go to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/mesh_edge_collector_pkg.sv
// Shared types and constants for the mesh edge collector.
package mesh_edge_collector_pkg;

  // Default thread PC width; a thread payload carries one extra flag bit.
  localparam int THREAD_PC_WIDTH = 8;
  localparam int THREAD_WIDTH    = THREAD_PC_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } mesh_edge_state_t;

  // Which input wins the last free slot.
  typedef enum logic {
    PRIO_Y = 1'b0,
    PRIO_X = 1'b1
  } prio_t;

  function automatic int payload_width(input int pc_width);
    return pc_width + 1;
  endfunction

endpackage

// File: rtl/mesh_edge_collector_if.sv
// Valid/ready thread channel between mesh nodes and the edge collector.
interface channel_iface
  import mesh_edge_collector_pkg::*;
#(
  parameter int DATA_WIDTH          = THREAD_WIDTH,
  parameter int LATENCY_COUNT_WIDTH = 8
);

  logic                           valid;
  logic                           ready;
  logic [DATA_WIDTH-1:0]          data;
  logic [LATENCY_COUNT_WIDTH-1:0] latency;

  // Receiving side of a channel.
  modport in  (input valid, input data, output ready);
  // Sending side of a channel.
  modport out (output valid, output data, output latency, input ready);

endinterface

// File: rtl/mesh_edge_collector_fifo.sv
// thread_fifo: ordered thread buffer with up to two pushes and one pop per cycle.
// Entry a is written ahead of entry b when both push in the same cycle.
module thread_fifo #(
  parameter int WIDTH       = 9,
  parameter int COUNT_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push_a,
  input  logic [WIDTH-1:0]       data_a,
  input  logic                   push_b,
  input  logic [WIDTH-1:0]       data_b,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [COUNT_WIDTH:0]   count
);

  localparam int DEPTH = 1 << COUNT_WIDTH;
  localparam int CW    = COUNT_WIDTH + 1;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [COUNT_WIDTH-1:0] wptr;
  logic [COUNT_WIDTH-1:0] rptr;
  logic [COUNT_WIDTH-1:0] wptr_b;

  // Second write lands one slot after the first when both push.
  assign wptr_b = wptr + COUNT_WIDTH'(push_a);
  assign head   = mem[rptr];

  // Storage writes.
  // NOTE: the data array has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_a) mem[wptr]   <= data_a;
    if (push_b) mem[wptr_b] <= data_b;
  end

  // Pointers and occupancy; the caller never overflows or underflows.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + COUNT_WIDTH'(push_a) + COUNT_WIDTH'(push_b);
      rptr  <= rptr + COUNT_WIDTH'(pop);
      count <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end

endmodule

// File: rtl/mesh_edge_collector.sv
// mesh_edge_collector: merges threads leaving the mesh east and south edges
// into one ordered stream that re-enters the first mesh node.
module mesh_edge_collector
  import mesh_edge_collector_pkg::*;
#(
  parameter int PC_WIDTH            = THREAD_PC_WIDTH,
  parameter int LATENCY_COUNT_WIDTH = 8,
  parameter int FIFO_COUNT_WIDTH    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  channel_iface.in                  x_in,
  channel_iface.in                  y_in,
  channel_iface.out                 out,
  input  logic                      flush,
  output logic [FIFO_COUNT_WIDTH:0] count,
  output logic                      full,
  output logic                      running
);

  localparam int W     = payload_width(PC_WIDTH);
  localparam int DEPTH = 1 << FIFO_COUNT_WIDTH;
  localparam int CW    = FIFO_COUNT_WIDTH + 1;

  mesh_edge_state_t state;
  mesh_edge_state_t state_next;
  prio_t            prio;
  logic             armed;
  logic             blocked;
  logic             free_two;
  logic             free_one;
  logic             x_fire;
  logic             y_fire;
  logic             push_a;
  logic             push_b;
  logic             pop;
  logic [W-1:0]     data_a;
  logic [W-1:0]     head;

  // Readies come only from registered state and flush, never from a valid.
  assign blocked  = flush || (state == FLUSH) || !armed;
  assign free_two = (count <= CW'(DEPTH - 2));
  assign free_one = (count == CW'(DEPTH - 1));

  // Input acceptance: both ports with room for two, the priority port with room for one.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    x_in.ready = 1'b0;
    y_in.ready = 1'b0;
    if (!blocked) begin
      if (free_two) begin
        x_in.ready = 1'b1;
        y_in.ready = 1'b1;
      end else if (free_one) begin
        x_in.ready = (prio == PRIO_X);
        y_in.ready = (prio == PRIO_Y);
      end
    end
  end

  assign x_fire = x_in.valid && x_in.ready;
  assign y_fire = y_in.valid && y_in.ready;

  // y is enqueued ahead of x on a dual transfer.
  assign push_a = x_fire || y_fire;
  assign push_b = x_fire && y_fire;
  assign data_a = y_fire ? y_in.data : x_in.data;

  assign out.valid   = (count != '0) && (state != FLUSH) && !flush;
  assign out.data    = head;
  assign out.latency = LATENCY_COUNT_WIDTH'(0);
  assign pop         = out.valid && out.ready;

  assign full    = (count == CW'(DEPTH));
  assign running = (count != '0) || x_in.valid || y_in.valid || (state == FLUSH);

  thread_fifo #(
    .WIDTH       (W),
    .COUNT_WIDTH (FIFO_COUNT_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .push_a (push_a),
    .data_a (data_a),
    .push_b (push_b),
    .data_b (x_in.data),
    .pop    (pop),
    .head   (head),
    .count  (count)
  );

  // State register; armed holds readies low until the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
    end
  end

  // Next-state: flush dominates, otherwise track whether the buffer holds work.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = FLUSH;
    end else begin
      unique case (state)
        IDLE:    if (push_a) state_next = ACTIVE;
        ACTIVE:  if ((count == CW'(1)) && pop && !push_a) state_next = IDLE;
        FLUSH:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Priority toggles after each transfer into the last free slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio <= PRIO_Y;
    end else if (flush) begin
      prio <= PRIO_Y;
    end else if (free_one && push_a) begin
      prio <= (prio == PRIO_Y) ? PRIO_X : PRIO_Y;
    end
  end

endmodule

// File: tb/tb_mesh_edge_collector.sv
// Self-checking bench for mesh_edge_collector with an output-order scoreboard.
module tb_mesh_edge_collector;
  import mesh_edge_collector_pkg::*;

  localparam int PCW   = 8;
  localparam int LCW   = 8;
  localparam int FCW   = 3;
  localparam int W     = PCW + 1;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [FCW:0] count;
  logic         full;
  logic         running;

  channel_iface #(.DATA_WIDTH(W), .LATENCY_COUNT_WIDTH(LCW)) x_if ();
  channel_iface #(.DATA_WIDTH(W), .LATENCY_COUNT_WIDTH(LCW)) y_if ();
  channel_iface #(.DATA_WIDTH(W), .LATENCY_COUNT_WIDTH(LCW)) o_if ();

  mesh_edge_collector #(
    .PC_WIDTH            (PCW),
    .LATENCY_COUNT_WIDTH (LCW),
    .FIFO_COUNT_WIDTH    (FCW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .x_in    (x_if),
    .y_in    (y_if),
    .out     (o_if),
    .flush   (flush),
    .count   (count),
    .full    (full),
    .running (running)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb [$];

  // Scoreboard: accepted inputs are queued (y before x), pops are compared in order.
  always @(posedge clk) begin
    if (rst) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (o_if.valid && o_if.ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_pop_empty: got %h with nothing expected", o_if.data);
          end else begin
            logic [W-1:0] exp;
            exp = sb.pop_front();
            if (o_if.data !== exp) begin
              errors++;
              $display("FAIL sb_order: got %h expected %h", o_if.data, exp);
            end
          end
        end
        if (y_if.valid && y_if.ready) sb.push_back(y_if.data);
        if (x_if.valid && x_if.ready) sb.push_back(x_if.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    x_if.valid = 1'b0;
    y_if.valid = 1'b0;
    x_if.data  = '0;
    y_if.data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; o_if.ready = 1'b0;
    idle_inputs();
    #12;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", full); end
    checks++; if (o_if.valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", o_if.valid); end
    checks++; if ({x_if.ready, y_if.ready} !== 2'b00) begin errors++; $display("FAIL rst_readies: got %b expected 00", {x_if.ready, y_if.ready}); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({x_if.ready, y_if.ready} !== 2'b00) begin errors++; $display("FAIL rst_release_readies: got %b expected 00", {x_if.ready, y_if.ready}); end
    tick();
    checks++; if ({x_if.ready, y_if.ready} !== 2'b11) begin errors++; $display("FAIL first_edge_readies: got %b expected 11", {x_if.ready, y_if.ready}); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dut.state, IDLE); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running: got %b expected 0", running); end
  endtask

  task automatic test_single();
    o_if.ready = 1'b1;
    x_if.valid = 1'b1; x_if.data = 9'h105;
    #1;
    checks++; if (o_if.valid !== 1'b0) begin errors++; $display("FAIL single_no_comb: got %b expected 0", o_if.valid); end
    tick();
    checks++; if (o_if.valid !== 1'b1 || o_if.data !== 9'h105) begin errors++; $display("FAIL single_first: got v=%b d=%h expected v=1 d=105", o_if.valid, o_if.data); end
    checks++; if (o_if.latency !== 8'd0) begin errors++; $display("FAIL out_latency: got %h expected 00", o_if.latency); end
    x_if.data = 9'h003;
    tick();
    checks++; if (o_if.data !== 9'h003 || count !== 4'd1) begin errors++; $display("FAIL single_second: got d=%h c=%0d expected d=003 c=1", o_if.data, count); end
    idle_inputs();
    tick();
    checks++; if (count !== 4'd0 || o_if.valid !== 1'b0) begin errors++; $display("FAIL single_drain: got c=%0d v=%b expected c=0 v=0", count, o_if.valid); end
  endtask

  task automatic test_dual();
    o_if.ready = 1'b1;
    x_if.valid = 1'b1; x_if.data = 9'h011;
    y_if.valid = 1'b1; y_if.data = 9'h022;
    #1;
    checks++; if ({x_if.ready, y_if.ready} !== 2'b11) begin errors++; $display("FAIL dual_readies: got %b expected 11", {x_if.ready, y_if.ready}); end
    tick();
    idle_inputs();
    checks++; if (count !== 4'd2 || o_if.data !== 9'h022) begin errors++; $display("FAIL dual_first: got c=%0d d=%h expected c=2 d=022", count, o_if.data); end
    tick();
    checks++; if (count !== 4'd1 || o_if.data !== 9'h011) begin errors++; $display("FAIL dual_second: got c=%0d d=%h expected c=1 d=011", count, o_if.data); end
    tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL dual_drain: got %0d expected 0", count); end
  endtask

  // Odd start so that count lands on DEPTH-1 with both ports valid.
  task automatic fill_to_seven(input logic [W-1:0] base);
    o_if.ready = 1'b0;
    x_if.valid = 1'b1; x_if.data = base;
    tick();
    y_if.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x_if.data = base + W'(2 * i + 1);
      y_if.data = base + W'(2 * i + 2);
      tick();
    end
  endtask

  task automatic test_fill();
    fill_to_seven(9'h100);
    checks++; if (count !== 4'd7 || full !== 1'b0) begin errors++; $display("FAIL fill_seven: got c=%0d f=%b expected c=7 f=0", count, full); end
    checks++; if ({x_if.ready, y_if.ready} !== 2'b01) begin errors++; $display("FAIL fill_seven_y_first: got xy=%b expected 01", {x_if.ready, y_if.ready}); end
    x_if.data = 9'h1F0; y_if.data = 9'h0F0;
    tick();
    checks++; if (count !== 4'(DEPTH) || full !== 1'b1) begin errors++; $display("FAIL fill_full: got c=%0d f=%b expected c=8 f=1", count, full); end
    checks++; if ({x_if.ready, y_if.ready} !== 2'b00) begin errors++; $display("FAIL fill_full_readies: got %b expected 00", {x_if.ready, y_if.ready}); end
    idle_inputs();
    o_if.ready = 1'b1;
    repeat (DEPTH) tick();
    checks++; if (count !== 4'd0 || sb.size() != 0) begin errors++; $display("FAIL fill_drain: got c=%0d q=%0d expected 0 0", count, sb.size()); end
    fill_to_seven(9'h040);
    checks++; if ({x_if.ready, y_if.ready} !== 2'b10) begin errors++; $display("FAIL refill_x_next: got xy=%b expected 10", {x_if.ready, y_if.ready}); end
    x_if.data = 9'h1E0; y_if.data = 9'h0E0;
    tick();
    checks++; if (count !== 4'(DEPTH)) begin errors++; $display("FAIL refill_full: got %0d expected 8", count); end
  endtask

  task automatic test_full_pop();
    o_if.ready = 1'b1;
    #1;
    checks++; if ({x_if.ready, y_if.ready} !== 2'b00) begin errors++; $display("FAIL full_pop_no_bypass: got %b expected 00", {x_if.ready, y_if.ready}); end
    tick();
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_pop_only: got %0d expected 7", count); end
    checks++; if ({x_if.ready, y_if.ready} !== 2'b01) begin errors++; $display("FAIL full_pop_prio_y: got xy=%b expected 01", {x_if.ready, y_if.ready}); end
    x_if.data = 9'h1D1; y_if.data = 9'h0D1;
    tick();
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_push_resume: got %0d expected 7", count); end
    checks++; if ({x_if.ready, y_if.ready} !== 2'b10) begin errors++; $display("FAIL full_prio_toggle: got xy=%b expected 10", {x_if.ready, y_if.ready}); end
    idle_inputs();
    repeat (7) tick();
    checks++; if (count !== 4'd0 || o_if.valid !== 1'b0 || sb.size() != 0) begin errors++; $display("FAIL full_drain: got c=%0d v=%b q=%0d expected 0 0 0", count, o_if.valid, sb.size()); end
  endtask

  task automatic test_flush();
    o_if.ready = 1'b0;
    x_if.valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x_if.data = 9'h0C0 + W'(i);
      tick();
    end
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_prefill: got %0d expected 5", count); end
    flush = 1'b1;
    #1;
    checks++; if ({x_if.ready, y_if.ready, o_if.valid} !== 3'b000) begin errors++; $display("FAIL flush_blocks: got xyv=%b expected 000", {x_if.ready, y_if.ready, o_if.valid}); end
    tick();
    checks++; if (count !== 4'd0 || o_if.valid !== 1'b0 || dut.state !== FLUSH) begin errors++; $display("FAIL flush_edge: got c=%0d v=%b s=%0d expected c=0 v=0 s=%0d", count, o_if.valid, dut.state, FLUSH); end
    flush = 1'b0;
    idle_inputs();
    #1;
    checks++; if (running !== 1'b1 || x_if.ready !== 1'b0) begin errors++; $display("FAIL flush_state: got run=%b rdy=%b expected run=1 rdy=0", running, x_if.ready); end
    tick();
    checks++; if (dut.state !== IDLE || running !== 1'b0 || {x_if.ready, y_if.ready} !== 2'b11) begin errors++; $display("FAIL flush_exit: got s=%0d run=%b xy=%b expected s=%0d run=0 xy=11", dut.state, running, {x_if.ready, y_if.ready}, IDLE); end
  endtask

  task automatic test_async_reset();
    o_if.ready = 1'b0;
    x_if.valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x_if.data = 9'h150 + W'(i);
      tick();
    end
    checks++; if (count !== 4'd4 || o_if.valid !== 1'b1) begin errors++; $display("FAIL arst_prefill: got c=%0d v=%b expected c=4 v=1", count, o_if.valid); end
    idle_inputs();
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    checks++; if (count !== 4'd0 || o_if.valid !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL arst_immediate: got c=%0d v=%b f=%b expected 0 0 0", count, o_if.valid, full); end
    checks++; if ({x_if.ready, y_if.ready} !== 2'b00) begin errors++; $display("FAIL arst_readies: got %b expected 00", {x_if.ready, y_if.ready}); end
    #1;
    rst = 1'b1;
    tick();
    checks++; if ({x_if.ready, y_if.ready} !== 2'b11 || count !== 4'd0) begin errors++; $display("FAIL arst_recover: got xy=%b c=%0d expected xy=11 c=0", {x_if.ready, y_if.ready}, count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_fill();
    test_full_pop();
    test_flush();
    test_async_reset();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
